mrecv_byte: RTL and testbench

MRECV_BYTE -- requirements
Module: mrecv_byte

---
 rtl/mrecv_byte.sv | 151 +++++++++++++++
 tb/tb_mrecv_byte.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mrecv_byte.sv
// rtl/mrecv_byte.sv - oversampling serial frame receiver, MSB-first payload
// Majority-of-three sampling around mid-bit; stop bit is validated before recv_data updates.
module mrecv_byte #(
  parameter int OSR    = 16,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              unit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] recv_data,
  output logic              recv_valid,
  output logic              frame_err,
  output logic              receiving
);

  localparam int CNT_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0]  CNT_S0    = CNT_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_S1    = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0]  CNT_S2    = CNT_W'(OSR / 2 + 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic              rx_meta_q;
  logic              rx_s_q;
  logic              rx_d_q;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [2:0]        samp_q, samp_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] recv_data_q, recv_data_d;
  logic              recv_valid_q, recv_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              majority;
  logic              start_edge;

  // Synchronizer presets high so a released reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign majority   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign start_edge = rx_d_q & ~rx_s_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bidx_d       = bidx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    recv_data_d  = recv_data_q;
    recv_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (!unit_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bidx_d  = '0;
    end else if (state_q == ST_IDLE) begin
      if (start_edge) begin
        state_d = ST_START;
        cnt_d   = '0;
        bidx_d  = '0;
      end
    end else begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_S0) samp_d[0] = rx_s_q;
      if (cnt_q == CNT_S1) samp_d[1] = rx_s_q;
      if (cnt_q == CNT_S2) samp_d[2] = rx_s_q;

      if (cnt_q == CNT_LAST) begin
        case (state_q)
          ST_START: begin
            if (!majority) begin
              state_d = ST_DATA;
              bidx_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_DATA: begin
            shift_d = (shift_q << 1) | DATA_W'(majority);
            if (bidx_q == BIDX_LAST) begin
              state_d = ST_STOP;
            end else begin
              bidx_d = bidx_q + BIDX_W'(1);
            end
          end
          ST_STOP: begin
            if (majority) begin
              recv_data_d  = shift_q;
              recv_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            bidx_d = '0;
            // A gapless next start edge lands on this very cycle; catch it here or it is lost.
            state_d = start_edge ? ST_START : ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bidx_q       <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      recv_data_q  <= '0;
      recv_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bidx_q       <= bidx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      recv_data_q  <= recv_data_d;
      recv_valid_q <= recv_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign recv_data  = recv_data_q;
  assign recv_valid = recv_valid_q;
  assign frame_err  = frame_err_q;
  assign receiving  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mrecv_byte.sv
// tb/tb_mrecv_byte.sv - directed self-checking bench for mrecv_byte
// Frames are driven bit by bit; a negedge monitor logs pulses and receiving edges.
module tb_mrecv_byte;

  localparam int OSR    = 16;
  localparam int DATA_W = 24;
  localparam int LAT    = (DATA_W + 2) * OSR;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              unit_en = 1'b0;
  logic              rx = 1'b1;
  logic [DATA_W-1:0] recv_data;
  logic              recv_valid;
  logic              frame_err;
  logic              receiving;

  mrecv_byte #(.OSR(OSR), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .unit_en    (unit_en),
    .rx         (rx),
    .recv_data  (recv_data),
    .recv_valid (recv_valid),
    .frame_err  (frame_err),
    .receiving  (receiving)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int              valid_cnt = 0;
  int              err_cnt = 0;
  int              both_cnt = 0;
  int              start_cyc = 0;
  int              end_cyc = 0;
  logic            prev_recv = 1'b0;
  int              v_cyc [16];
  logic [DATA_W-1:0] v_data [16];

  always @(negedge clk) begin
    if (receiving && !prev_recv) start_cyc = cyc;
    if (!receiving && prev_recv) end_cyc = cyc;
    prev_recv = receiving;
    if (recv_valid && frame_err) both_cnt++;
    if (recv_valid) begin
      if (valid_cnt < 16) begin
        v_cyc[valid_cnt]  = cyc;
        v_data[valid_cnt] = recv_data;
      end
      valid_cnt++;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    for (int i = 0; i < OSR; i++) begin
      rx = (glitch && i == 8) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop, input logic glitch, output int p);
    p = cyc;
    send_bit(1'b0, 1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i], glitch);
    send_bit(stop, 1'b0);
    rx = 1'b1;
  endtask

  int p0, p1, k, vc, ec;

  initial begin
    rstn = 1'b0;
    unit_en = 1'b1;
    rx = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_recv_data", 32'(recv_data), 32'h0);
    check_eq("rst_recv_valid", 32'(recv_valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_receiving", 32'(receiving), 32'h0);
    rstn = 1'b1;
    idle(5);

    // good frame and latency
    k = valid_cnt;
    send_frame(24'h123456, 1'b1, 1'b0, p0);
    idle(10);
    check_eq("f1_valid_count", 32'(valid_cnt - k), 32'd1);
    check_eq("f1_data", 32'(v_data[k]), 32'h123456);
    check_eq("f1_start_entry", 32'(start_cyc), 32'(p0 + 3));
    check_eq("f1_latency", 32'(v_cyc[k] - start_cyc), 32'(LAT));
    check_eq("f1_err_count", 32'(err_cnt), 32'd0);
    check_eq("f1_receiving_low", 32'(receiving), 32'h0);

    // short low glitch on the line
    vc = valid_cnt;
    ec = err_cnt;
    p0 = cyc;
    rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    idle(30);
    check_eq("glitch_start", 32'(start_cyc), 32'(p0 + 3));
    check_eq("glitch_duration", 32'(end_cyc - start_cyc), 32'(OSR));
    check_eq("glitch_no_valid", 32'(valid_cnt - vc), 32'd0);
    check_eq("glitch_no_err", 32'(err_cnt - ec), 32'd0);

    // bad stop bit
    vc = valid_cnt;
    ec = err_cnt;
    send_frame(24'hABCDEF, 1'b0, 1'b0, p0);
    idle(10);
    check_eq("ferr_count", 32'(err_cnt - ec), 32'd1);
    check_eq("ferr_no_valid", 32'(valid_cnt - vc), 32'd0);
    check_eq("ferr_data_held", 32'(recv_data), 32'h123456);

    // back-to-back frames with no idle gap
    k = valid_cnt;
    send_frame(24'hA5A5A5, 1'b1, 1'b0, p0);
    send_frame(24'h5A5A5A, 1'b1, 1'b0, p1);
    idle(10);
    check_eq("b2b_valid_count", 32'(valid_cnt - k), 32'd2);
    check_eq("b2b_data0", 32'(v_data[k]), 32'hA5A5A5);
    check_eq("b2b_data1", 32'(v_data[k+1]), 32'h5A5A5A);
    check_eq("b2b_spacing", 32'(v_cyc[k+1] - v_cyc[k]), 32'(LAT));

    // unit_en dropped during data bit 10
    vc = valid_cnt;
    ec = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = DATA_W - 1; i > DATA_W - 11; i--) send_bit(1'b1, 1'b0);
    rx = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check_eq("en_receiving_before", 32'(receiving), 32'h1);
    unit_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("en_receiving_off", 32'(receiving), 32'h0);
    idle(30);
    check_eq("en_no_pulse", 32'((valid_cnt - vc) + (err_cnt - ec)), 32'd0);
    check_eq("en_data_held", 32'(recv_data), 32'h5A5A5A);
    unit_en = 1'b1;
    idle(5);
    k = valid_cnt;
    send_frame(24'h0F0F0F, 1'b1, 1'b0, p0);
    idle(10);
    check_eq("en_next_count", 32'(valid_cnt - k), 32'd1);
    check_eq("en_next_data", 32'(recv_data), 32'h0F0F0F);

    // one inverted sample per data bit
    k = valid_cnt;
    send_frame(24'hFFFFFF, 1'b1, 1'b1, p0);
    idle(10);
    check_eq("noise_count", 32'(valid_cnt - k), 32'd1);
    check_eq("noise_data", 32'(recv_data), 32'hFFFFFF);

    // reset in the middle of a frame
    vc = valid_cnt;
    ec = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mrst_recv_data", 32'(recv_data), 32'h0);
    check_eq("mrst_recv_valid", 32'(recv_valid), 32'h0);
    check_eq("mrst_frame_err", 32'(frame_err), 32'h0);
    check_eq("mrst_receiving", 32'(receiving), 32'h0);
    idle(2);
    rstn = 1'b1;
    idle(30);
    check_eq("mrst_no_pulse", 32'((valid_cnt - vc) + (err_cnt - ec)), 32'd0);
    k = valid_cnt;
    send_frame(24'h3C3C3C, 1'b1, 1'b0, p0);
    idle(10);
    check_eq("mrst_next_count", 32'(valid_cnt - k), 32'd1);
    check_eq("mrst_next_data", 32'(recv_data), 32'h3C3C3C);
    check_eq("mrst_next_latency", 32'(v_cyc[k] - start_cyc), 32'(LAT));

    check_eq("never_both", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
